// File: rtl/scancode_if.sv
// scancode_if: scan byte input, ASCII FIFO output and status flags for scancode_decoder
interface scancode_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       overflow;
  logic       shift_active;
  logic       caps_active;
  modport master (output scan_code, scan_valid, ascii_ready,
                  input  ascii, ascii_valid, overflow, shift_active, caps_active);
  modport slave  (input  scan_code, scan_valid, ascii_ready,
                  output ascii, ascii_valid, overflow, shift_active, caps_active);
endinterface

// File: rtl/scancode_decoder.sv
// scancode_decoder: PS/2 set-2 scan bytes to ASCII through an output FIFO; define CAPS_LOCK_EN for caps lock
module scancode_decoder #(
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] DEFAULT_CHAR = 8'h2A,
  parameter bit         EMIT_UNKNOWN = 1'b1
) (
  input logic       clk,
  input logic       reset,
  scancode_if.slave kb
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  state_t state;
  logic lshift, rshift, caps, ovf;
  logic [7:0] code, ch;
  logic [8:0] hit_ch;
  logic is_make, is_mod, emit, pop, push, full;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  // letters return lowercase base; non-letters carry {unshifted, shifted}
  function automatic logic [8:0] lookup(input logic [7:0] c, input logic up, input logic sh);
    logic [7:0] b, s;
    b = 8'h00;
    s = 8'h00;
    case (c)
      8'h1C: b = "a";  8'h32: b = "b";  8'h21: b = "c";  8'h23: b = "d";
      8'h24: b = "e";  8'h2B: b = "f";  8'h34: b = "g";  8'h33: b = "h";
      8'h43: b = "i";  8'h3B: b = "j";  8'h42: b = "k";  8'h4B: b = "l";
      8'h3A: b = "m";  8'h31: b = "n";  8'h44: b = "o";  8'h4D: b = "p";
      8'h15: b = "q";  8'h2D: b = "r";  8'h1B: b = "s";  8'h2C: b = "t";
      8'h3C: b = "u";  8'h2A: b = "v";  8'h1D: b = "w";  8'h22: b = "x";
      8'h35: b = "y";  8'h1A: b = "z";
      8'h16: {b, s} = 16'h3121;  8'h1E: {b, s} = 16'h3240;
      8'h26: {b, s} = 16'h3323;  8'h25: {b, s} = 16'h3424;
      8'h2E: {b, s} = 16'h3525;  8'h36: {b, s} = 16'h365E;
      8'h3D: {b, s} = 16'h3726;  8'h3E: {b, s} = 16'h382A;
      8'h46: {b, s} = 16'h3928;  8'h45: {b, s} = 16'h3029;
      8'h0E: {b, s} = 16'h607E;  8'h4E: {b, s} = 16'h2D5F;
      8'h55: {b, s} = 16'h3D2B;  8'h54: {b, s} = 16'h5B7B;
      8'h5B: {b, s} = 16'h5D7D;  8'h5D: {b, s} = 16'h5C7C;
      8'h4C: {b, s} = 16'h3B3A;  8'h52: {b, s} = 16'h2722;
      8'h41: {b, s} = 16'h2C3C;  8'h49: {b, s} = 16'h2E3E;
      8'h4A: {b, s} = 16'h2F3F;
      8'h29: {b, s} = 16'h2020;  8'h5A: {b, s} = 16'h0D0D;
      8'h66: {b, s} = 16'h0808;  8'h0D: {b, s} = 16'h0909;
      8'h76: {b, s} = 16'h1B1B;
      default: ;
    endcase
    if (b >= "a" && b <= "z") return {1'b1, up ? b - 8'h20 : b};
    return {b != 8'h00, sh ? s : b};
  endfunction
`ifdef CAPS_LOCK_EN
  localparam bit CAPS_EN = 1'b1;
  always_ff @(posedge clk)
    if (reset) caps <= 1'b0;
    else if (is_make && code == 8'h58) caps <= ~caps;
`else
  localparam bit CAPS_EN = 1'b0;
  assign caps = 1'b0;
`endif
  assign code    = kb.scan_code;
  assign hit_ch  = lookup(code, (lshift | rshift) ^ caps, lshift | rshift);
  assign is_make = kb.scan_valid && state == IDLE && code != 8'hF0 && code != 8'hE0;
  assign is_mod  = code == 8'h12 || code == 8'h59 || (CAPS_EN && code == 8'h58);
  assign emit    = (is_make && !is_mod && (hit_ch[8] || EMIT_UNKNOWN)) ||
                   (kb.scan_valid && state == EXT && code == 8'h5A);
  assign ch      = state == EXT ? 8'h0D : hit_ch[8] ? hit_ch[7:0] : DEFAULT_CHAR;
  assign full    = cnt == (AW+1)'(FIFO_DEPTH);
  assign pop     = kb.ascii_valid && kb.ascii_ready;
  assign push    = emit && (!full || pop);
  always_ff @(posedge clk)
    if (reset) begin
      state  <= IDLE;
      lshift <= 1'b0;
      rshift <= 1'b0;
    end else if (kb.scan_valid) begin
      state  <= code == 8'hF0 && state == IDLE ? BRK :
                code == 8'hF0 && state == EXT  ? EXT_BRK :
                code == 8'hE0 && state == IDLE ? EXT : IDLE;
      lshift <= state == IDLE && code == 8'h12 ? 1'b1 : state == BRK && code == 8'h12 ? 1'b0 : lshift;
      rshift <= state == IDLE && code == 8'h59 ? 1'b1 : state == BRK && code == 8'h59 ? 1'b0 : rshift;
    end
  always_ff @(posedge clk)
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= ch;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (emit && full && !pop) ovf <= 1'b1;
    end
  assign kb.ascii_valid  = cnt != '0;
  assign kb.ascii        = kb.ascii_valid ? mem[rp] : 8'h00;
  assign kb.overflow     = ovf;
  assign kb.shift_active = lshift | rshift;
  assign kb.caps_active  = caps;
endmodule

// File: doc/scancode_decoder.md
SCANCODE_DECODER -- requirements
Module: scancode_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output FIFO entries; power of two, 2..64.
REQ-002 Parameter DEFAULT_CHAR, default 8'h2A, code emitted for unmapped make codes.
REQ-003 Parameter EMIT_UNKNOWN, default 1; 0 means unmapped make codes are dropped.
REQ-004 Port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port scan_code  in  8  PS/2 set-2 scan byte from the receiver.
REQ-007 Port scan_valid  in  1  one-cycle strobe qualifying scan_code.
REQ-008 Port ascii  out  8  ASCII at the FIFO head.
REQ-009 Port ascii_valid  out  1  high while the FIFO is non-empty.
REQ-010 Port ascii_ready  in  1  consumer accept; pop when ascii_valid & ascii_ready.
REQ-011 Port overflow  out  1  sticky; a character was dropped because the FIFO was full.
REQ-012 Port shift_active  out  1  high while left or right shift is held.
REQ-013 Port caps_active  out  1  caps-lock toggle state (tied 0 without CAPS_LOCK_EN).

Function
REQ-014 Prefix FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0); advance only on scan_valid.
REQ-015 IDLE: F0->BRK, E0->EXT, other byte = make code, processed, stay IDLE.
REQ-016 EXT: F0->EXT_BRK; else extended make code, return to IDLE. BRK and EXT_BRK: byte = break code, return to IDLE.
REQ-017 Make 12 or 59 (IDLE) sets the matching shift flag, no output; break 12/59 clears it; shift_active = OR of both flags.
REQ-018 Letters (set-2 codes for A..Z) emit uppercase when shift_active XOR caps_active, else lowercase (41..5A / 61..7A).
REQ-019 Digits 0..9 and punctuation ` - = [ ] \ ; ' , . / emit base ASCII unshifted; shifted: ) ! @ # $ % ^ & * ( ~ _ + { } | : " < > ?; caps never affects them.
REQ-020 29->20 (space), 5A->0D, 66->08, 0D->09 (tab), 76->1B (esc), all shift-independent.
REQ-021 Extended make E0 5A emits 0D; other extended makes, all break codes, and modifier makes emit nothing.
REQ-022 Other make codes emit DEFAULT_CHAR if EMIT_UNKNOWN=1, else nothing.
REQ-023 Latency: emitting byte with scan_valid at edge N is written to FIFO at edge N; ascii_valid high after edge N if FIFO was empty.
REQ-024 FIFO first-in-first-out; ascii stable while ascii_valid & !ascii_ready.
REQ-025 Full and no pop same cycle: new char dropped, overflow set, held until reset.
REQ-026 Full with pop same cycle: push accepted, no overflow.
REQ-027 Empty: push-and-pop same cycle impossible (ascii_valid low); push proceeds normally.
REQ-028 Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-029 scan_valid low: no FSM, flag, or FIFO write change.

Reset
REQ-030 reset high at an edge: FSM->IDLE, FIFO empty, ascii_valid=0, ascii=00, overflow=0, shift flags=0, caps_active=0.
REQ-031 Reset mid-sequence (after F0 or E0) discards the prefix; next byte is decoded from IDLE.
REQ-032 reset dominates scan_valid and ascii_ready in the same cycle.

Configuration
REQ-033 Macro CAPS_LOCK_EN defined: make 58 in IDLE toggles caps_active, no output; break 58 ignored; key repeat (repeated makes) toggles each time.
REQ-034 CAPS_LOCK_EN undefined: no caps register, caps_active tied 0, code 58 treated as unmapped per REQ-022.

Verification
REQ-035 Reset; 1C, ready=1 -> ascii=61 ('a') one cycle after; F0 1C -> no output.
REQ-036 12, 16, F0 16, F0 12, 16 -> outputs 21 ('!') then 31 ('1'); shift_active 1 then 0.
REQ-037 With CAPS_LOCK_EN: 58, 1C, 12, 1C, 16 -> 41, 61, 21; caps_active=1.
REQ-038 ready=0, FIFO_DEPTH=8, nine 29 makes -> eight 20 queued, overflow=1; drain gives exactly eight 20.
REQ-039 E0 5A -> 0D; E0 75 -> nothing; 0E ignored? no: 0E -> 60; 07 -> 2A (EMIT_UNKNOWN=1).
REQ-040 F0 then reset then 1C -> 61 emitted (prefix discarded), overflow=0.
